// File: rtl/wfg_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wfg_core_pkg
// Description : Shared types and widths for the waveform generator core.
// Revision    : 1.0 - initial release
// ============================================================================
package wfg_core_pkg;

    localparam int WFG_CORE_SUBCYCLE_W = 16;
    localparam int WFG_CORE_SYNC_W     = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wfg_core_tick_state_t;

endpackage
`default_nettype wire

// File: rtl/wfg_core_tick_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wfg_core_tick_cnt
// Description : Wrap counter; returns to zero on the increment where cnt >= limit.
// Revision    : 1.0 - initial release
// ============================================================================
module wfg_core_tick_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // >= lets a lowered limit wrap immediately instead of running to overflow
    always_comb begin
        wrap  = inc && !clr && (cnt_q >= limit);
        cnt_d = cnt_q;
        if (clr || wrap) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/wfg_core_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : wfg_core_tick_gen
// Description : Subcycle/sync pulse generator. Define WFG_CORE_TICK_SHADOW_EN
//               to latch N/M at enable and at each sync wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module wfg_core_tick_gen
    import wfg_core_pkg::*;
#(
    parameter int SUBCYCLE_W = WFG_CORE_SUBCYCLE_W,
    parameter int SYNC_W     = WFG_CORE_SYNC_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [SUBCYCLE_W-1:0] subcycle_i,
    input  logic [SYNC_W-1:0]     sync_i,
    output logic                  subcycle_pulse_o,
    output logic                  sync_pulse_o,
    output logic [SYNC_W-1:0]     subcycle_cnt_o,
    output logic                  active_o
);

    wfg_core_tick_state_t state_q, state_d;

    logic                  cnt_clr;
    logic                  sub_inc;
    logic [SUBCYCLE_W-1:0] sub_cnt;
    logic                  sub_wrap;
    logic [SYNC_W-1:0]     sync_cnt;
    logic                  sync_wrap;
    logic [SUBCYCLE_W-1:0] n_lim;
    logic [SYNC_W-1:0]     m_lim;

    logic              sub_pulse_q, sub_pulse_d;
    logic              sync_pulse_q, sync_pulse_d;
    logic [SYNC_W-1:0] sub_idx_q, sub_idx_d;
    logic              active_q, active_d;
    logic [SYNC_W-1:0] sync_nxt;
    logic              sub_zero_nxt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i)  state_d = RUN;
            RUN:     if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters restart from zero on entry to RUN and are held clear elsewhere
    assign cnt_clr = (state_q != RUN) || !en_i;
    assign sub_inc = !cnt_clr;

`ifdef WFG_CORE_TICK_SHADOW_EN
    logic [SUBCYCLE_W-1:0] n_shadow_q, n_shadow_d;
    logic [SYNC_W-1:0]     m_shadow_q, m_shadow_d;
    logic                  shadow_load;

    always_comb begin
        shadow_load = ((state_q == IDLE) && en_i) || sync_wrap;
        n_shadow_d  = shadow_load ? subcycle_i : n_shadow_q;
        m_shadow_d  = shadow_load ? sync_i     : m_shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_shadow_q <= '0;
            m_shadow_q <= '0;
        end else begin
            n_shadow_q <= n_shadow_d;
            m_shadow_q <= m_shadow_d;
        end
    end

    assign n_lim = n_shadow_q;
    assign m_lim = m_shadow_q;
`else
    assign n_lim = subcycle_i;
    assign m_lim = sync_i;
`endif

    wfg_core_tick_cnt #(.W(SUBCYCLE_W)) u_sub_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (sub_inc),
        .limit (n_lim),
        .cnt   (sub_cnt),
        .wrap  (sub_wrap)
    );

    wfg_core_tick_cnt #(.W(SYNC_W)) u_sync_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (sub_wrap),
        .limit (m_lim),
        .cnt   (sync_cnt),
        .wrap  (sync_wrap)
    );

    // Outputs are registered from the counters' next values so they align
    // with the cycle the counters enter, not the one they leave.
    always_comb begin
        sub_zero_nxt = cnt_clr || sub_wrap;
        sync_nxt     = sync_cnt;
        if (cnt_clr || sync_wrap) begin
            sync_nxt = '0;
        end else if (sub_wrap) begin
            sync_nxt = sync_cnt + SYNC_W'(1);
        end
        active_d     = (state_d == RUN);
        sub_pulse_d  = active_d && sub_zero_nxt;
        sync_pulse_d = active_d && sub_zero_nxt && (sync_nxt == '0);
        sub_idx_d    = active_d ? sync_nxt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sub_pulse_q  <= 1'b0;
            sync_pulse_q <= 1'b0;
            sub_idx_q    <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sub_pulse_q  <= sub_pulse_d;
            sync_pulse_q <= sync_pulse_d;
            sub_idx_q    <= sub_idx_d;
            active_q     <= active_d;
        end
    end

    assign subcycle_pulse_o = sub_pulse_q;
    assign sync_pulse_o     = sync_pulse_q;
    assign subcycle_cnt_o   = sub_idx_q;
    assign active_o         = active_q;

endmodule
`default_nettype wire

// File: tb/tb_wfg_core_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfg_core_tick_gen
// Description : Self-checking bench for wfg_core_tick_gen (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfg_core_tick_gen;

    logic        clk;
    logic        rst_n;
    logic        en_i;
    logic [15:0] subcycle_i;
    logic [7:0]  sync_i;
    logic        subcycle_pulse_o;
    logic        sync_pulse_o;
    logic [7:0]  subcycle_cnt_o;
    logic        active_o;

    int n_checks;
    int n_fail;

    wfg_core_tick_gen #(.SUBCYCLE_W(16), .SYNC_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_i             (en_i),
        .subcycle_i       (subcycle_i),
        .sync_i           (sync_i),
        .subcycle_pulse_o (subcycle_pulse_o),
        .sync_pulse_o     (sync_pulse_o),
        .subcycle_cnt_o   (subcycle_cnt_o),
        .active_o         (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive enable, take one clock edge, and return 1 time unit later.
    task automatic tick(input logic en);
        en_i = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic sp, input logic syp,
                             input logic [7:0] cnt, input logic act);
        check_eq({tag, ".sub"},  32'(subcycle_pulse_o), 32'(sp));
        check_eq({tag, ".sync"}, 32'(sync_pulse_o),     32'(syp));
        check_eq({tag, ".cnt"},  32'(subcycle_cnt_o),   32'(cnt));
        check_eq({tag, ".act"},  32'(active_o),         32'(act));
    endtask

    // Reference model: elapsed cycles since enable, everything else by arithmetic
    bit running;
    int t;

    task automatic model_step(input logic en);
        if (en) begin
            if (running) t++;
            else begin
                running = 1'b1;
                t = 0;
            end
        end else begin
            running = 1'b0;
        end
    endtask

    task automatic model_check(input string tag);
        int n1, m1;
        n1 = int'(subcycle_i) + 1;
        m1 = int'(sync_i) + 1;
        if (running)
            check_all(tag, (t % n1) == 0, (t % (n1 * m1)) == 0, 8'((t / n1) % m1), 1'b1);
        else
            check_all(tag, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] sub_mask, sync_mask, exp_sub, exp_sync;
        logic [7:0]  idx_at[4];
        int          cnt_ok, spurious;
        logic        en_r;

        n_checks   = 0;
        n_fail     = 0;
        running    = 1'b0;
        t          = 0;
        rst_n      = 1'b0;
        en_i       = 1'b0;
        subcycle_i = 16'd5;
        sync_i     = 8'd3;

        // Reset state
        tick(1'b1);
        tick(1'b1);
        check_all("reset", 1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0);

        // Asynchronous reset mid-run
        for (int c = 0; c < 10; c++) tick(1'b1);
        check_eq("prerst.act", 32'(active_o), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 1'b0, 8'd0, 1'b0);
        tick(1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) tick(1'b0);
        check_eq("postrst.idle", 32'(active_o), 32'd0);
        tick(1'b1);
        check_all("postrst.en", 1'b1, 1'b1, 8'd0, 1'b1);
        tick(1'b0);

        // Basic periods N=3, M=2
        subcycle_i = 16'd3;
        sync_i     = 8'd2;
        sub_mask   = '0;
        sync_mask  = '0;
        for (int c = 0; c <= 16; c++) begin
            tick(1'b1);
            sub_mask[c]  = subcycle_pulse_o;
            sync_mask[c] = sync_pulse_o;
            if (c % 4 == 0 && c < 16) idx_at[c / 4] = subcycle_cnt_o;
        end
        check_eq("basic.sub_mask",  sub_mask,  32'h0001_1111);
        check_eq("basic.sync_mask", sync_mask, 32'h0000_1001);
        check_eq("basic.idx0", 32'(idx_at[0]), 32'd0);
        check_eq("basic.idx4", 32'(idx_at[1]), 32'd1);
        check_eq("basic.idx8", 32'(idx_at[2]), 32'd2);
        check_eq("basic.idx12", 32'(idx_at[3]), 32'd0);
        tick(1'b0);

        // Degenerate N=0, M=0
        subcycle_i = 16'd0;
        sync_i     = 8'd0;
        cnt_ok     = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1);
            if (subcycle_pulse_o && sync_pulse_o && subcycle_cnt_o == 8'd0) cnt_ok++;
        end
        check_eq("degen.cycles", 32'(cnt_ok), 32'd20);
        tick(1'b0);

        // Abort at edge 5, restart at edge 6
        subcycle_i = 16'd9;
        sync_i     = 8'd1;
        for (int c = 0; c < 5; c++) tick(1'b1);
        tick(1'b0);
        check_all("abort", 1'b0, 1'b0, 8'd0, 1'b0);
        tick(1'b1);
        check_all("restart", 1'b1, 1'b1, 8'd0, 1'b1);
        tick(1'b0);

        // Live reconfig: N 9 -> 3 while sub_cnt == 7, M=1
        subcycle_i = 16'd9;
        sync_i     = 8'd1;
        sub_mask   = '0;
        sync_mask  = '0;
        for (int c = 0; c < 32; c++) begin
            tick(1'b1);
            sub_mask[c]  = subcycle_pulse_o;
            sync_mask[c] = sync_pulse_o;
            if (c == 7) subcycle_i = 16'd3;
        end
`ifdef WFG_CORE_TICK_SHADOW_EN
        exp_sub  = (32'd1 << 0) | (32'd1 << 10) | (32'd1 << 20) | (32'd1 << 24) | (32'd1 << 28);
        exp_sync = (32'd1 << 0) | (32'd1 << 20) | (32'd1 << 28);
`else
        exp_sub  = (32'd1 << 0) | (32'd1 << 8) | (32'd1 << 12) | (32'd1 << 16)
                 | (32'd1 << 20) | (32'd1 << 24) | (32'd1 << 28);
        exp_sync = (32'd1 << 0) | (32'd1 << 12) | (32'd1 << 20) | (32'd1 << 28);
`endif
        check_eq("reconfig.sub_mask",  sub_mask,  exp_sub);
        check_eq("reconfig.sync_mask", sync_mask, exp_sync);
        tick(1'b0);

        // Randomized runs against the reference model
        running = 1'b0;
        en_r    = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (en_r) begin
                if ($urandom_range(24, 0) == 0) en_r = 1'b0;
            end else begin
                if ($urandom_range(2, 0) == 0) en_r = 1'b1;
                else begin
                    subcycle_i = 16'($urandom_range(6, 0));
                    sync_i     = 8'($urandom_range(4, 0));
                end
            end
            tick(en_r);
            model_step(en_r);
            model_check("rand");
        end
        tick(1'b0);

        // Max field: N=16'hFFFF, M=0, one full period
        subcycle_i = 16'hFFFF;
        sync_i     = 8'd0;
        tick(1'b1);
        check_all("max.first", 1'b1, 1'b1, 8'd0, 1'b1);
        spurious = 0;
        for (int c = 1; c < 65536; c++) begin
            tick(1'b1);
            if (subcycle_pulse_o || sync_pulse_o) spurious++;
        end
        check_eq("max.spurious", 32'(spurious), 32'd0);
        tick(1'b1);
        check_all("max.second", 1'b1, 1'b1, 8'd0, 1'b1);
        tick(1'b0);
        check_all("max.stop", 1'b0, 1'b0, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
